// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and default widths for the APB master arbiter slice.
package apb_master_arbiter_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module apb_rr_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N_REQ-1:0] eligible;
    int unsigned      pos;

    assign eligible = req & ~mask;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            pos = (32'(ptr) + k) % N_REQ;
            if (!grant_valid && eligible[pos[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port among N_REQ requesters, with optional wait-state timeout.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PADDR_SIZE = APB_ADDR_W,
    parameter int unsigned PDATA_SIZE = APB_DATA_W,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ*PADDR_SIZE-1:0]   req_addr,
    input  logic [N_REQ*PDATA_SIZE-1:0]   req_wdata,
    input  logic [N_REQ*PDATA_SIZE/8-1:0] req_strb,
    output logic [N_REQ-1:0]              req_done,
    output logic [PDATA_SIZE-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_timeout,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [PADDR_SIZE-1:0]         PADDR,
    output logic [PDATA_SIZE-1:0]         PWDATA,
    output logic [PDATA_SIZE/8-1:0]       PSTRB,
    input  logic [PDATA_SIZE-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int unsigned IDX_W  = clog2_min1(N_REQ);
    localparam int unsigned STRB_W = PDATA_SIZE / 8;
    localparam int unsigned CNT_W  = clog2_min1(TIMEOUT);

    apb_state_e       state, state_n;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             xfer_ok;
    logic             xfer_abort;
    logic             take;
    int unsigned      sel;

    // The requester just completed still shows req_valid during its done pulse; keep it out.
    apb_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .mask        (req_done),
        .ptr         (ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign take        = (state == APB_IDLE) && arb_valid;
    assign sel         = 32'(arb_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= APB_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        xfer_ok    = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            APB_IDLE: begin
                if (arb_valid) state_n = APB_SETUP;
            end
            APB_SETUP: begin
                PSEL    = 1'b1;
                state_n = APB_ACCESS;
            end
            APB_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    xfer_ok = 1'b1;
                    state_n = APB_IDLE;
                end else if (timeout_hit) begin
                    xfer_abort = 1'b1;
                    state_n    = APB_IDLE;
                end
            end
            default: state_n = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= IDX_W'(N_REQ - 1);
            grant  <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (take) begin
            ptr    <= arb_idx;
            grant  <= arb_idx;
            PADDR  <= req_addr[sel*PADDR_SIZE +: PADDR_SIZE];
            PWRITE <= req_write[arb_idx];
            PWDATA <= req_write[arb_idx] ? req_wdata[sel*PDATA_SIZE +: PDATA_SIZE] : '0;
            PSTRB  <= req_write[arb_idx] ? req_strb[sel*STRB_W +: STRB_W] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == APB_SETUP) begin
            cnt <= '0;
        end else if ((state == APB_ACCESS) && !PREADY && (TIMEOUT != 0) && !timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            if (xfer_ok) begin
                req_done  <= N_REQ'(1) << grant;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (xfer_abort) begin
                req_done    <= N_REQ'(1) << grant;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: stimulus pushes expected transfers, a negedge monitor checks APB phases and responses.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N*SW-1:0]   req_strb  = '0;
    logic [N-1:0]      req_done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [SW-1:0]     PSTRB;
    logic [DW-1:0]     PRDATA  = '0;
    logic              PREADY  = 1'b0;
    logic              PSLVERR = 1'b1;

    apb_master_arbiter #(
        .N_REQ      (N),
        .PADDR_SIZE (AW),
        .PDATA_SIZE (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_done    (req_done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
        int          issue;
        int          gap;
    } exp_t;

    exp_t sbq[$];

    // Slave model: PREADY after cfg_wait stall cycles; PRDATA/PSLVERR are junk while not ready.
    int          cfg_wait   = 0;
    logic [31:0] cfg_prdata = '0;
    logic        cfg_err    = 1'b0;
    int          wcnt       = 0;

    always @(negedge clk) begin
        if (PSEL && PENABLE) begin
            if (wcnt == cfg_wait) begin
                PREADY  = 1'b1;
                PRDATA  = cfg_prdata;
                PSLVERR = cfg_err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 32'h0BAD_0BAD;
                PSLVERR = 1'b1;
                wcnt    = wcnt + 1;
            end
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'h0BAD_0BAD;
            PSLVERR = 1'b1;
            wcnt    = 0;
        end
    end

    int setup_cyc = 0;
    int last_done = 0;

    always @(negedge clk) begin
        exp_t h;
        if (rst) begin
            if (PSEL && !PENABLE) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_setup", 32'(PADDR), 32'hFFFF_FFFF);
                end else begin
                    h = sbq[0];
                    chk("setup_paddr",  PADDR,         h.addr);
                    chk("setup_pwrite", 32'(PWRITE),   32'(h.wr));
                    chk("setup_pwdata", PWDATA,        h.wdata);
                    chk("setup_pstrb",  32'(PSTRB),    32'(h.strb));
                    if (h.issue >= 0) chk("setup_cycle", 32'(cyc), 32'(h.issue + 1));
                    if (h.gap >= 0)   chk("b2b_gap", 32'(cyc - last_done), 32'(h.gap));
                    setup_cyc = cyc;
                end
            end
            if (PSEL && PENABLE && sbq.size() != 0) begin
                chk("access_paddr",  PADDR,  sbq[0].addr);
                chk("access_pwdata", PWDATA, sbq[0].wdata);
            end
            if (req_done != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(req_done), 32'h0);
                end else begin
                    h = sbq.pop_front();
                    chk("req_done",     32'(req_done),    32'(1) << h.idx);
                    chk("rsp_rdata",    rsp_rdata,        h.rdata);
                    chk("rsp_err",      32'(rsp_err),     32'(h.err));
                    chk("rsp_timeout",  32'(rsp_timeout), 32'(h.tmo));
                    chk("latency",      32'(cyc - setup_cyc), 32'(h.lat));
                    chk("psel_in_done", 32'({PSEL, PENABLE}), 32'h0);
                end
                last_done = cyc;
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
    endtask

    task automatic push_exp(input int i, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic [31:0] rd, input logic er, input logic tmo,
                            input int lat, input int issue, input int gap);
        exp_t e;
        e.idx   = i;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = wr ? d : 32'h0;
        e.strb  = wr ? s : 4'h0;
        e.rdata = rd;
        e.err   = er;
        e.tmo   = tmo;
        e.lat   = lat;
        e.issue = issue;
        e.gap   = gap;
        sbq.push_back(e);
    endtask

    task automatic xfer(input int i, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int waits, input logic [31:0] prd, input logic serr,
                        input logic [31:0] exp_rd, input logic exp_er, input logic exp_to,
                        input int lat, input bit drop_early);
        bit got;
        @(negedge clk);
        cfg_wait   = waits;
        cfg_prdata = prd;
        cfg_err    = serr;
        set_req(i, wr, a, d, s);
        push_exp(i, wr, a, d, s, exp_rd, exp_er, exp_to, lat, cyc, -1);
        req_valid[i] = 1'b1;
        if (drop_early) begin
            for (int c = 0; c < 20 && !PSEL; c++) @(negedge clk);
            req_valid[i] = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_done[i]) got = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk("done_seen", 32'(got), 32'h1);
        if (!got) sbq.delete();
    endtask

    initial begin
        int nacc;
        int ndone;

        repeat (3) @(negedge clk);
        chk("rst_psel",    32'({PSEL, PENABLE}), 32'h0);
        chk("rst_done",    32'(req_done), 32'h0);
        chk("rst_rsp",     32'({rsp_err, rsp_timeout}), 32'h0);
        chk("rst_rdata",   rsp_rdata, 32'h0);
        chk("rst_paddr",   PADDR, 32'h0);
        rst = 1'b1;

        // Single writes/reads, wait states, timeout and its boundary, slave error.
        xfer(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0,   32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 2,  1'b0);
        xfer(1, 1'b0, 32'h24, 32'h1111_2222, 4'hF, 3,   32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5,  1'b1);
        xfer(3, 1'b0, 32'h3C, 32'h0,         4'h0, 255, 32'h5555_AAAA, 1'b0, 32'h0,         1'b1, 1'b1, 17, 1'b0);
        xfer(2, 1'b0, 32'h38, 32'h0,         4'h0, 15,  32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0, 1'b0, 17, 1'b0);
        xfer(0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'h3, 0,   32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 2,  1'b0);
        xfer(1, 1'b0, 32'h44, 32'hFFFF_FFFF, 4'hF, 1,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3,  1'b0);

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_psel", 32'(PSEL), 32'h0);
        end

        // Reset in the middle of an ACCESS phase.
        @(negedge clk);
        cfg_wait = 255;
        set_req(2, 1'b1, 32'h80, 32'h8888_0000, 4'hF);
        push_exp(2, 1'b1, 32'h80, 32'h8888_0000, 4'hF, 32'h0, 1'b0, 1'b0, 2, -1, -1);
        req_valid[2] = 1'b1;
        nacc = 0;
        for (int c = 0; c < 40 && nacc < 3; c++) begin
            @(negedge clk);
            if (PSEL && PENABLE) nacc = nacc + 1;
        end
        chk("mid_access_reached", 32'(nacc), 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_apb",  32'({PSEL, PENABLE}), 32'h0);
        chk("mid_rst_done", 32'(req_done), 32'h0);
        sbq.delete();
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(req_done), 32'h0);
        end
        rst = 1'b1;

        // All requesters held valid: strict rotation starting from 0, 3 cycles per transfer.
        @(negedge clk);
        cfg_wait   = 0;
        cfg_prdata = 32'hCAFE_0000;
        cfg_err    = 1'b0;
        set_req(0, 1'b1, 32'h100, 32'h1000_0000, 4'hF);
        set_req(1, 1'b0, 32'h104, 32'h0,         4'hF);
        set_req(2, 1'b1, 32'h108, 32'h2000_0002, 4'hC);
        set_req(3, 1'b0, 32'h10C, 32'h0,         4'hF);
        push_exp(0, 1'b1, 32'h100, 32'h1000_0000, 4'hF, 32'h0,         1'b0, 1'b0, 2, cyc, -1);
        push_exp(1, 1'b0, 32'h104, 32'h0,         4'hF, 32'hCAFE_0000, 1'b0, 1'b0, 2, -1, 1);
        push_exp(2, 1'b1, 32'h108, 32'h2000_0002, 4'hC, 32'h0,         1'b0, 1'b0, 2, -1, 1);
        push_exp(3, 1'b0, 32'h10C, 32'h0,         4'hF, 32'hCAFE_0000, 1'b0, 1'b0, 2, -1, 1);
        push_exp(0, 1'b1, 32'h100, 32'h1000_0000, 4'hF, 32'h0,         1'b0, 1'b0, 2, -1, 1);
        req_valid = '1;
        ndone = 0;
        for (int c = 0; c < 100 && ndone < 5; c++) begin
            @(negedge clk);
            if (req_done != '0) ndone = ndone + 1;
        end
        req_valid = '0;
        chk("rot_done_count", 32'(ndone), 32'd5);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
